// File: rtl/vx_bitmanip_unit.sv
// vx_bitmanip_unit: two-stage Zbb-style bitmanip execute unit.
// S1 latches the request and its selected operand B; S2 latches the per-lane results. Both stall together on commit backpressure.
module vx_bitmanip_unit #(
  parameter int NUM_THREADS = 4,
  parameter int UUID_BITS   = 44,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         req_valid,
  input  logic [UUID_BITS-1:0]         req_uuid,
  input  logic [NW_BITS-1:0]           req_wid,
  input  logic [NUM_THREADS-1:0]       req_tmask,
  input  logic [31:0]                  req_PC,
  input  logic [3:0]                   req_op_type,
  input  logic                         req_use_imm,
  input  logic [31:0]                  req_imm,
  input  logic [NUM_THREADS-1:0][31:0] req_rs1_data,
  input  logic [NUM_THREADS-1:0][31:0] req_rs2_data,
  input  logic [NR_BITS-1:0]           req_rd,
  input  logic                         req_wb,
  output logic                         req_ready,

  output logic                         commit_valid,
  output logic [UUID_BITS-1:0]         commit_uuid,
  output logic [NW_BITS-1:0]           commit_wid,
  output logic [NUM_THREADS-1:0]       commit_tmask,
  output logic [31:0]                  commit_PC,
  output logic [NUM_THREADS-1:0][31:0] commit_data,
  output logic [NR_BITS-1:0]           commit_rd,
  output logic                         commit_wb,
  output logic                         commit_eop,
  input  logic                         commit_ready,

  output logic [31:0]                  perf_ops
);

  typedef enum logic [3:0] {
    OP_CLZ   = 4'd0,
    OP_CTZ   = 4'd1,
    OP_CPOP  = 4'd2,
    OP_ANDN  = 4'd3,
    OP_ORN   = 4'd4,
    OP_XNOR  = 4'd5,
    OP_MIN   = 4'd6,
    OP_MAX   = 4'd7,
    OP_MINU  = 4'd8,
    OP_MAXU  = 4'd9,
    OP_ROL   = 4'd10,
    OP_ROR   = 4'd11,
    OP_SEXTB = 4'd12,
    OP_SEXTH = 4'd13,
    OP_REV8  = 4'd14,
    OP_ORCB  = 4'd15
  } op_e;

  function automatic logic [31:0] f_exec(input op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [5:0]  cnt;
    logic [63:0] w;
    r   = '0;
    cnt = '0;
    w   = '0;
    unique case (op)
      OP_CLZ: begin
        cnt = 6'd32;
        for (int unsigned i = 0; i < 32; i++)
          if (a[i]) cnt = 6'(31 - i);
        r = {26'd0, cnt};
      end
      OP_CTZ: begin
        cnt = 6'd32;
        for (int unsigned i = 0; i < 32; i++)
          if (a[31 - i]) cnt = 6'(31 - i);
        r = {26'd0, cnt};
      end
      OP_CPOP: begin
        for (int unsigned i = 0; i < 32; i++)
          cnt = cnt + {5'd0, a[i]};
        r = {26'd0, cnt};
      end
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_XNOR: r = ~(a ^ b);
      OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  r = ($signed(a) < $signed(b)) ? b : a;
      OP_MINU: r = (a < b) ? a : b;
      OP_MAXU: r = (a < b) ? b : a;
      // Rotates shift a doubled copy so that amount 0 needs no special case.
      OP_ROL: begin
        w = {a, a} << b[4:0];
        r = w[63:32];
      end
      OP_ROR: begin
        w = {a, a} >> b[4:0];
        r = w[31:0];
      end
      OP_SEXTB: r = {{24{a[7]}}, a[7:0]};
      OP_SEXTH: r = {{16{a[15]}}, a[15:0]};
      OP_REV8:  r = {a[7:0], a[15:8], a[23:16], a[31:24]};
      OP_ORCB: begin
        for (int unsigned k = 0; k < 4; k++)
          r[k*8 +: 8] = (|a[k*8 +: 8]) ? 8'hFF : 8'h00;
      end
    endcase
    return r;
  endfunction

  logic                         r_s1_valid;
  logic [UUID_BITS-1:0]         r_s1_uuid;
  logic [NW_BITS-1:0]           r_s1_wid;
  logic [NUM_THREADS-1:0]       r_s1_tmask;
  logic [31:0]                  r_s1_PC;
  logic [NR_BITS-1:0]           r_s1_rd;
  logic                         r_s1_wb;
  op_e                          r_s1_op;
  logic [NUM_THREADS-1:0][31:0] r_s1_a;
  logic [NUM_THREADS-1:0][31:0] r_s1_b;

  logic                         r_s2_valid;
  logic [UUID_BITS-1:0]         r_s2_uuid;
  logic [NW_BITS-1:0]           r_s2_wid;
  logic [NUM_THREADS-1:0]       r_s2_tmask;
  logic [31:0]                  r_s2_PC;
  logic [NR_BITS-1:0]           r_s2_rd;
  logic                         r_s2_wb;
  logic [NUM_THREADS-1:0][31:0] r_s2_data;

  logic [31:0]                  r_perf_ops;

  logic                         w_advance;
  logic [NUM_THREADS-1:0][31:0] w_req_b;
  logic [NUM_THREADS-1:0][31:0] w_s1_result;

  // An empty S2 always accepts, so a lone S1 entry slides forward even under backpressure.
  assign w_advance = ~r_s2_valid | commit_ready;
  assign req_ready = w_advance & ~reset;

  always_comb begin
    w_req_b = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++)
      w_req_b[t] = req_use_imm ? req_imm : req_rs2_data[t];
  end

  always_comb begin
    w_s1_result = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++)
      w_s1_result[t] = r_s1_tmask[t] ? f_exec(r_s1_op, r_s1_a[t], r_s1_b[t]) : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_perf_ops <= '0;
    end else begin
      if (w_advance) begin
        r_s2_valid <= r_s1_valid;
        r_s1_valid <= req_valid & req_ready;
      end
      if (r_s2_valid & commit_ready)
        r_perf_ops <= r_perf_ops + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_s2_uuid  <= r_s1_uuid;
      r_s2_wid   <= r_s1_wid;
      r_s2_tmask <= r_s1_tmask;
      r_s2_PC    <= r_s1_PC;
      r_s2_rd    <= r_s1_rd;
      r_s2_wb    <= r_s1_wb;
      r_s2_data  <= w_s1_result;
      r_s1_uuid  <= req_uuid;
      r_s1_wid   <= req_wid;
      r_s1_tmask <= req_tmask;
      r_s1_PC    <= req_PC;
      r_s1_rd    <= req_rd;
      r_s1_wb    <= req_wb;
      r_s1_op    <= op_e'(req_op_type);
      r_s1_a     <= req_rs1_data;
      r_s1_b     <= w_req_b;
    end
  end

  assign commit_valid = r_s2_valid;
  assign commit_uuid  = r_s2_uuid;
  assign commit_wid   = r_s2_wid;
  assign commit_tmask = r_s2_tmask;
  assign commit_PC    = r_s2_PC;
  assign commit_data  = r_s2_data;
  assign commit_rd    = r_s2_rd;
  assign commit_wb    = r_s2_wb;
  assign commit_eop   = 1'b1;
  assign perf_ops     = r_perf_ops;

endmodule

// File: tb/tb_vx_bitmanip_unit.sv
// Self-checking bench for vx_bitmanip_unit: directed + random requests against a scoreboard of expected commits.
module tb_vx_bitmanip_unit;
  localparam int NT = 4;
  localparam int UB = 44;
  localparam int NWB = 2;
  localparam int NRB = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid;
  logic [UB-1:0]       req_uuid;
  logic [NWB-1:0]      req_wid;
  logic [NT-1:0]       req_tmask;
  logic [31:0]         req_PC;
  logic [3:0]          req_op_type;
  logic                req_use_imm;
  logic [31:0]         req_imm;
  logic [NT-1:0][31:0] req_rs1_data;
  logic [NT-1:0][31:0] req_rs2_data;
  logic [NRB-1:0]      req_rd;
  logic                req_wb;
  logic                req_ready;
  logic                commit_valid;
  logic [UB-1:0]       commit_uuid;
  logic [NWB-1:0]      commit_wid;
  logic [NT-1:0]       commit_tmask;
  logic [31:0]         commit_PC;
  logic [NT-1:0][31:0] commit_data;
  logic [NRB-1:0]      commit_rd;
  logic                commit_wb;
  logic                commit_eop;
  logic                commit_ready;
  logic [31:0]         perf_ops;

  vx_bitmanip_unit #(.NUM_THREADS(NT), .UUID_BITS(UB), .NW_BITS(NWB), .NR_BITS(NRB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_uuid(req_uuid), .req_wid(req_wid), .req_tmask(req_tmask),
    .req_PC(req_PC), .req_op_type(req_op_type), .req_use_imm(req_use_imm), .req_imm(req_imm),
    .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data), .req_rd(req_rd), .req_wb(req_wb),
    .req_ready(req_ready),
    .commit_valid(commit_valid), .commit_uuid(commit_uuid), .commit_wid(commit_wid),
    .commit_tmask(commit_tmask), .commit_PC(commit_PC), .commit_data(commit_data),
    .commit_rd(commit_rd), .commit_wb(commit_wb), .commit_eop(commit_eop),
    .commit_ready(commit_ready), .perf_ops(perf_ops)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [UB-1:0]       uuid;
    logic [NWB-1:0]      wid;
    logic [NT-1:0]       tmask;
    logic [31:0]         pc;
    logic [NRB-1:0]      rd;
    logic                wb;
    logic [NT-1:0][31:0] data;
    int unsigned         acc;
    bit                  lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned n_commit = 0;
  logic [31:0] m_perf = '0;
  logic [UB-1:0] uuid_ctr = '0;
  bit          lat_chk = 0;
  bit          rand_ready = 0;
  bit          stall_prev = 0;
  logic [UB-1:0]       h_uuid;
  logic [31:0]         h_pc;
  logic [NT-1:0][31:0] h_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference semantics of each op, written from the ISA definitions.
  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int n;
    int s;
    r = '0;
    s = int'(b % 32);
    case (op)
      4'd0: begin n = 0; while (n < 32 && a[31-n] == 1'b0) n++; r = 32'(n); end
      4'd1: begin n = 0; while (n < 32 && a[n] == 1'b0) n++; r = 32'(n); end
      4'd2: r = 32'($countones(a));
      4'd3: r = a & ~b;
      4'd4: r = a | ~b;
      4'd5: r = ~(a ^ b);
      4'd6: r = ($signed(a) <= $signed(b)) ? a : b;
      4'd7: r = ($signed(a) >= $signed(b)) ? a : b;
      4'd8: r = (a <= b) ? a : b;
      4'd9: r = (a >= b) ? a : b;
      4'd10: r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      4'd11: r = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      4'd12: r = 32'($signed(a[7:0]));
      4'd13: r = 32'($signed(a[15:0]));
      4'd14: for (int k = 0; k < 4; k++) r[8*(3-k) +: 8] = a[8*k +: 8];
      default: for (int k = 0; k < 4; k++) r[8*k +: 8] = (a[8*k +: 8] != 8'd0) ? 8'hFF : 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [NT-1:0][31:0] rep(input logic [31:0] x);
    return {x, x, x, x};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    check("perf_ops", perf_ops, m_perf);
    if (stall_prev) begin
      check("stall_valid", commit_valid, 1);
      check("stall_uuid", commit_uuid, h_uuid);
      check("stall_pc", commit_PC, h_pc);
      check("stall_data_lo", commit_data[1:0], h_data[1:0]);
      check("stall_data_hi", commit_data[3:2], h_data[3:2]);
    end
    if (reset) begin
      exp_q.delete();
      m_perf = '0;
      stall_prev = 0;
    end else begin
      stall_prev = commit_valid && !commit_ready;
      h_uuid = commit_uuid;
      h_pc   = commit_PC;
      h_data = commit_data;
      if (commit_valid && commit_ready) begin
        check("commit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          check("uuid", commit_uuid, m_e.uuid);
          check("wid", commit_wid, m_e.wid);
          check("tmask", commit_tmask, m_e.tmask);
          check("pc", commit_PC, m_e.pc);
          check("rd", commit_rd, m_e.rd);
          check("wb", commit_wb, m_e.wb);
          check("eop", commit_eop, 1);
          for (int t = 0; t < NT; t++)
            check($sformatf("data[%0d] uuid=%0d", t, m_e.uuid), commit_data[t], m_e.data[t]);
          if (m_e.lat && lat_chk) check("latency", cyc - m_e.acc, 2);
        end
        n_commit++;
        m_perf = m_perf + 32'd1;
      end
      if (req_valid && req_ready) begin
        m_e.uuid  = req_uuid;
        m_e.wid   = req_wid;
        m_e.tmask = req_tmask;
        m_e.pc    = req_PC;
        m_e.rd    = req_rd;
        m_e.wb    = req_wb;
        for (int t = 0; t < NT; t++)
          m_e.data[t] = req_tmask[t] ?
            ref_op(req_op_type, req_rs1_data[t], req_use_imm ? req_imm : req_rs2_data[t]) : 32'd0;
        m_e.acc = cyc;
        m_e.lat = lat_chk;
        exp_q.push_back(m_e);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) commit_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [3:0] op, input logic ui, input logic [31:0] imm, input logic [NT-1:0] tm,
                      input logic [NT-1:0][31:0] a, input logic [NT-1:0][31:0] b);
    req_valid    = 1'b1;
    req_uuid     = uuid_ctr;
    uuid_ctr     = uuid_ctr + 1;
    req_wid      = NWB'($urandom);
    req_tmask    = tm;
    req_PC       = $urandom;
    req_op_type  = op;
    req_use_imm  = ui;
    req_imm      = imm;
    req_rs1_data = a;
    req_rs2_data = b;
    req_rd       = NRB'($urandom);
    req_wb       = 1'($urandom);
  endtask

  task automatic wait_accept();
    bit done;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic ui, input logic [31:0] imm, input logic [NT-1:0] tm,
                       input logic [NT-1:0][31:0] a, input logic [NT-1:0][31:0] b);
    load(op, ui, imm, tm, a, b);
    wait_accept();
  endtask

  logic [NT-1:0][31:0] va;
  logic [NT-1:0][31:0] vb;
  int unsigned base;

  initial begin
    reset = 1'b1; req_valid = 1'b0; commit_ready = 1'b1;
    req_uuid = '0; req_wid = '0; req_tmask = '0; req_PC = '0; req_op_type = '0;
    req_use_imm = 1'b0; req_imm = '0; req_rs1_data = '0; req_rs2_data = '0; req_rd = '0; req_wb = 1'b0;
    step(3);
    @(negedge clk);
    check("ready_in_reset", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_perf", perf_ops, 0);
    @(posedge clk); #1;

    // Backpressure: two entries fill the pipe, then the third request must wait.
    commit_ready = 1'b0;
    issue(4'd5, 1'b0, 0, 4'hF, rep(32'h1234_5678), rep(32'h0F0F_0F0F));
    issue(4'd3, 1'b0, 0, 4'hF, rep(32'hFFFF_0000), rep(32'h00FF_00FF));
    load(4'd4, 1'b0, 0, 4'hF, rep(32'h0000_1111), rep(32'hF0F0_0000));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_commit_valid", commit_valid, 1);
      @(posedge clk); #1;
    end
    commit_ready = 1'b1;
    wait_accept();
    issue(4'd9, 1'b0, 0, 4'hF, rep(32'h8000_0000), rep(32'h7FFF_FFFF));
    issue(4'd7, 1'b0, 0, 4'hF, rep(32'h8000_0000), rep(32'h7FFF_FFFF));
    step(4);
    check("bp_commits", n_commit, 5);
    check("bp_perf", perf_ops, 5);

    lat_chk = 1;
    va = {32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000};
    issue(4'd0, 1'b0, 0, 4'hF, va, rep(32'hDEAD_BEEF));
    issue(4'd1, 1'b0, 0, 4'hF, va, rep(32'hDEAD_BEEF));
    issue(4'd2, 1'b0, 0, 4'hF, va, rep(32'hDEAD_BEEF));
    issue(4'd11, 1'b1, 32'h24, 4'hF, rep(32'h1234_5678), rep(32'h0));
    issue(4'd10, 1'b0, 0, 4'hF, rep(32'hCAFE_F00D), rep(32'h0));
    issue(4'd6, 1'b0, 0, 4'hF, rep(32'hFFFF_FFFF), rep(32'h1));
    issue(4'd8, 1'b0, 0, 4'hF, rep(32'hFFFF_FFFF), rep(32'h1));
    issue(4'd14, 1'b0, 0, 4'hF, rep(32'h1122_3344), rep(32'h0));
    issue(4'd15, 1'b0, 0, 4'hF, rep(32'h0010_0001), rep(32'h0));
    issue(4'd12, 1'b0, 0, 4'hF, rep(32'h0000_0080), rep(32'h0));
    issue(4'd13, 1'b0, 0, 4'hF, rep(32'h0000_8000), rep(32'h0));
    issue(4'd5, 1'b0, 0, 4'b0101, {32'h1, 32'h2, 32'h3, 32'h4}, rep(32'h0F0F_0F0F));
    step(4);
    lat_chk = 0;

    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      for (int t = 0; t < NT; t++) begin
        va[t] = rnd_word();
        vb[t] = rnd_word();
      end
      issue(4'($urandom), 1'($urandom_range(0, 3) == 0), rnd_word(), 4'($urandom), va, vb);
      if ($urandom_range(0, 4) == 0) step(1);
    end
    rand_ready = 0;
    commit_ready = 1'b1;
    step(5);
    check("drain_empty", exp_q.size(), 0);

    // Reset with two entries in flight: nothing may commit afterwards.
    commit_ready = 1'b0;
    issue(4'd2, 1'b0, 0, 4'hF, rep(32'h0F0F_0F0F), rep(32'h0));
    issue(4'd0, 1'b0, 0, 4'hF, rep(32'h0000_00FF), rep(32'h0));
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    commit_ready = 1'b1;
    base = n_commit;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_commit_valid", commit_valid, 0);
      @(posedge clk); #1;
    end
    check("post_rst_perf", perf_ops, 0);
    check("post_rst_commits", n_commit - base, 0);

    @(posedge clk); #2;
    force dut.r_perf_ops = 32'hFFFF_FFFF;
    m_perf = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_ops;
    @(posedge clk); #1;
    issue(4'd1, 1'b0, 0, 4'hF, rep(32'h0000_0100), rep(32'h0));
    step(4);
    check("perf_wrap", perf_ops, 0);
    check("final_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
